// File: rtl/service_4_pkg.sv
// service_4 shared definitions: alarm-check state encodings, edit-field
// encodings, the power-on alarm time and the BCD limits for hours/minutes.
// Used by service_4_alarm_set and Service_4_alarm_check.
package service_4_pkg;

  // alarm_state encodings driven by the alarm-check block
  localparam logic [2:0] ALARM_ST_IDLE     = 3'b000;
  localparam logic [2:0] ALARM_ST_ARMED    = 3'b001;
  localparam logic [2:0] ALARM_ST_RINGING  = 3'b010;
  localparam logic [2:0] ALARM_ST_MINIGAME = 3'b100;

  // Setter states; the encoding is exactly what edit_field shows.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EDIT_H = 2'b01,
    ST_EDIT_M = 2'b10
  } set_state_e;

  localparam logic [15:0] ALARM_RESET_VAL = 16'h0700;
  localparam logic [7:0]  BCD_MAX_HOURS   = 8'h23;
  localparam logic [7:0]  BCD_MAX_MINUTES = 8'h59;

  // Editing is locked out while the alarm rings or the minigame runs.
  function automatic logic edit_blocked(input logic [2:0] st);
    return (st == ALARM_ST_RINGING) || (st == ALARM_ST_MINIGAME);
  endfunction

endpackage

// File: rtl/service_4_bcd_step.sv
// Combinational wrap-around up/down step on a two-digit BCD value.
// Ports: val_i (BCD value), max_i (BCD upper limit), inc_i/dec_i (step
//        requests, both together cancel), res_o (stepped BCD value).
module service_4_bcd_step (
  input  logic [7:0] val_i,
  input  logic [7:0] max_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] res_o
);

  logic [3:0] tens;
  logic [3:0] ones;
  logic       legal;

  always_comb begin
    tens  = val_i[7:4];
    ones  = val_i[3:0];
    legal = (tens <= 4'd9) && (ones <= 4'd9) && (val_i <= max_i);
    res_o = val_i;
    if (inc_i && !dec_i) begin
      // An illegal input snaps to the bottom of the range so the result
      // is always legal BCD.
      if (!legal || (val_i == max_i)) begin
        res_o = 8'h00;
      end else if (ones == 4'd9) begin
        res_o = {tens + 4'd1, 4'd0};
      end else begin
        res_o = {tens, ones + 4'd1};
      end
    end else if (dec_i && !inc_i) begin
      if (!legal || (val_i == 8'h00)) begin
        res_o = max_i;
      end else if (ones == 4'd0) begin
        res_o = {tens - 4'd1, 4'd9};
      end else begin
        res_o = {tens, ones - 4'd1};
      end
    end
  end

endmodule

// File: rtl/service_4_alarm_set.sv
// Alarm-time setter: SPDT_set enters edit mode, push_u/push_d step the active
// BCD field (with auto-repeat while held), push_m advances hours->minutes->commit.
// Ports: clk/resetn; SPDT_set, push_u/d/m, alarm_state in; alarm, alarm_valid,
//        edit_value, edit_field, commit out.
module service_4_alarm_set
  import service_4_pkg::*;
#(
  parameter int unsigned REPEAT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        SPDT_set,
  input  logic        push_u,
  input  logic        push_d,
  input  logic        push_m,
  input  logic [2:0]  alarm_state,
  output logic [15:0] alarm,
  output logic        alarm_valid,
  output logic [15:0] edit_value,
  output logic [1:0]  edit_field,
  output logic        commit
);

  localparam logic [31:0] REPEAT_LIM = 32'(REPEAT_CYCLES);

  set_state_e  state_q, state_d;
  logic [15:0] alarm_q, alarm_d;
  logic [15:0] edit_q, edit_d;
  logic        valid_q, valid_d;
  logic        commit_q, commit_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        u_prev_q, d_prev_q, m_prev_q;

  logic        u_press, d_press, m_press;
  logic        u_alone, d_alone;
  logic        rep_due, u_rep, d_rep;
  logic        inc, dec;
  logic        abort;
  logic [7:0]  hours_next, minutes_next;
  logic [15:0] edit_stepped;

  // Rising-edge press detection against the registered button history.
  assign u_press = push_u & ~u_prev_q;
  assign d_press = push_d & ~d_prev_q;
  assign m_press = push_m & ~m_prev_q;

  assign u_alone = push_u & ~push_d;
  assign d_alone = push_d & ~push_u;

  // hold_cnt_q is 1 in the cycle after the press, so reaching REPEAT_LIM
  // means REPEAT_CYCLES cycles have elapsed since the press or last repeat.
  assign rep_due = (hold_cnt_q != 32'd0) && (hold_cnt_q == REPEAT_LIM);
  assign u_rep   = u_alone & ~u_press & rep_due;
  assign d_rep   = d_alone & ~d_press & rep_due;
  assign inc     = u_press | u_rep;
  assign dec     = d_press | d_rep;

  assign abort = (state_q != ST_IDLE) && (!SPDT_set || edit_blocked(alarm_state));

  service_4_bcd_step u_hours_step (
    .val_i (edit_q[15:8]),
    .max_i (BCD_MAX_HOURS),
    .inc_i (inc && (state_q == ST_EDIT_H)),
    .dec_i (dec && (state_q == ST_EDIT_H)),
    .res_o (hours_next)
  );

  service_4_bcd_step u_minutes_step (
    .val_i (edit_q[7:0]),
    .max_i (BCD_MAX_MINUTES),
    .inc_i (inc && (state_q == ST_EDIT_M)),
    .dec_i (dec && (state_q == ST_EDIT_M)),
    .res_o (minutes_next)
  );

  assign edit_stepped = {hours_next, minutes_next};

  always_comb begin
    state_d  = state_q;
    alarm_d  = alarm_q;
    valid_d  = valid_q;
    commit_d = 1'b0;
    edit_d   = edit_q;
    unique case (state_q)
      ST_IDLE: begin
        // Working copy shadows the committed time, so entry starts from it.
        edit_d = alarm_q;
        if (SPDT_set && !edit_blocked(alarm_state)) begin
          state_d = ST_EDIT_H;
        end
      end
      ST_EDIT_H: begin
        if (abort) begin
          state_d = ST_IDLE;
          edit_d  = alarm_q;
        end else begin
          edit_d = edit_stepped;
          if (m_press) begin
            state_d = ST_EDIT_M;
          end
        end
      end
      ST_EDIT_M: begin
        if (abort) begin
          state_d = ST_IDLE;
          edit_d  = alarm_q;
        end else begin
          // A step pressed alongside the commit is kept, not dropped.
          edit_d = edit_stepped;
          if (m_press) begin
            state_d  = ST_IDLE;
            alarm_d  = edit_stepped;
            valid_d  = 1'b1;
            commit_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        edit_d  = alarm_q;
      end
    endcase
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((state_d != state_q) || (state_q == ST_IDLE) || !(u_alone || d_alone)) begin
      hold_cnt_d = 32'd0;
    end else if (u_press || d_press) begin
      hold_cnt_d = 32'd1;
    end else if (hold_cnt_q != 32'd0) begin
      hold_cnt_d = rep_due ? 32'd1 : hold_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      alarm_q    <= ALARM_RESET_VAL;
      edit_q     <= ALARM_RESET_VAL;
      valid_q    <= 1'b0;
      commit_q   <= 1'b0;
      hold_cnt_q <= 32'd0;
      u_prev_q   <= 1'b0;
      d_prev_q   <= 1'b0;
      m_prev_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      alarm_q    <= alarm_d;
      edit_q     <= edit_d;
      valid_q    <= valid_d;
      commit_q   <= commit_d;
      hold_cnt_q <= hold_cnt_d;
      u_prev_q   <= push_u;
      d_prev_q   <= push_d;
      m_prev_q   <= push_m;
    end
  end

  assign alarm       = alarm_q;
  assign alarm_valid = valid_q;
  assign edit_value  = edit_q;
  assign edit_field  = state_q;
  assign commit      = commit_q;

endmodule

// File: tb/tb_service_4_alarm_set.sv
module tb_service_4_alarm_set;

  logic        clk;
  logic        resetn;
  logic        SPDT_set;
  logic        push_u;
  logic        push_d;
  logic        push_m;
  logic [2:0]  alarm_state;
  logic [15:0] alarm;
  logic        alarm_valid;
  logic [15:0] edit_value;
  logic [1:0]  edit_field;
  logic        commit;

  int n_tests;
  int n_fail;

  service_4_alarm_set #(.REPEAT_CYCLES(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .SPDT_set    (SPDT_set),
    .push_u      (push_u),
    .push_d      (push_d),
    .push_m      (push_m),
    .alarm_state (alarm_state),
    .alarm       (alarm),
    .alarm_valid (alarm_valid),
    .edit_value  (edit_value),
    .edit_field  (edit_field),
    .commit      (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle press of any combination of buttons, then release.
  task automatic press(input logic u, input logic d, input logic m);
    push_u = u;
    push_d = d;
    push_m = m;
    tick();
    push_u = 1'b0;
    push_d = 1'b0;
    push_m = 1'b0;
    tick();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    resetn      = 1'b0;
    SPDT_set    = 1'b0;
    push_u      = 1'b0;
    push_d      = 1'b0;
    push_m      = 1'b0;
    alarm_state = 3'b000;
    repeat (2) tick();

    check("rst_alarm", alarm, 16'h0700);
    check("rst_edit", edit_value, 16'h0700);
    check("rst_valid", {15'd0, alarm_valid}, 16'd0);
    check("rst_field", {14'd0, edit_field}, 16'd0);
    check("rst_commit", {15'd0, commit}, 16'd0);
    resetn = 1'b1;
    tick();

    // Enter edit, hours 07 -> 10, minutes 00 -> 59, commit.
    SPDT_set = 1'b1;
    tick();
    check("enter_field", {14'd0, edit_field}, 16'h0001);
    check("enter_edit", edit_value, 16'h0700);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    check("hours_up3", edit_value, 16'h1000);
    press(1'b0, 1'b0, 1'b1);
    check("to_minutes", {14'd0, edit_field}, 16'h0002);
    press(1'b0, 1'b1, 1'b0);
    check("min_wrap_dn", edit_value, 16'h1059);
    push_m = 1'b1;
    tick();
    check("commit_pulse", {15'd0, commit}, 16'd1);
    check("commit_alarm", alarm, 16'h1059);
    check("commit_valid", {15'd0, alarm_valid}, 16'd1);
    check("commit_field", {14'd0, edit_field}, 16'd0);
    push_m = 1'b0;
    tick();
    check("commit_one_cycle", {15'd0, commit}, 16'd0);
    // SPDT_set is still high, so edit mode is re-entered from the new alarm.
    check("reenter_field", {14'd0, edit_field}, 16'h0001);
    check("reenter_edit", edit_value, 16'h1059);

    // Hours wrap: 10 down eleven times -> 23, then up -> 00.
    repeat (11) press(1'b0, 1'b1, 1'b0);
    check("hours_wrap_dn", edit_value, 16'h2359);
    press(1'b1, 1'b0, 1'b0);
    check("hours_wrap_up", edit_value, 16'h0059);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    check("min_wrap_up", edit_value, 16'h0000);
    press(1'b0, 1'b1, 1'b0);
    check("min_00_dn", edit_value, 16'h0059);
    press(1'b1, 1'b0, 1'b0);
    check("min_back_00", edit_value, 16'h0000);

    // Auto-repeat: 13 held cycles with REPEAT_CYCLES=4 -> press + 3 repeats.
    push_u = 1'b1;
    repeat (13) tick();
    push_u = 1'b0;
    tick();
    check("hold_repeat", edit_value, 16'h0004);
    repeat (6) tick();
    check("hold_released", edit_value, 16'h0004);

    // Ringing with push_m in the same cycle: abort wins, no commit.
    alarm_state = 3'b010;
    push_m      = 1'b1;
    tick();
    check("abort_field", {14'd0, edit_field}, 16'd0);
    check("abort_commit", {15'd0, commit}, 16'd0);
    check("abort_alarm", alarm, 16'h1059);
    check("abort_edit", edit_value, 16'h1059);
    push_m = 1'b0;
    tick();
    check("ringing_locked", {14'd0, edit_field}, 16'd0);
    alarm_state = 3'b000;
    tick();
    check("after_ring_enter", {14'd0, edit_field}, 16'h0001);

    // u and d together cancel.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("hours_12", edit_value, 16'h1259);
    press(1'b1, 1'b1, 1'b0);
    check("ud_cancel", edit_value, 16'h1259);

    // SPDT_set low aborts and reloads the working copy; IDLE ignores buttons.
    SPDT_set = 1'b0;
    tick();
    check("spdt_abort_field", {14'd0, edit_field}, 16'd0);
    check("spdt_abort_edit", edit_value, 16'h1059);
    press(1'b1, 1'b0, 1'b1);
    check("idle_ignores", edit_value, 16'h1059);
    check("idle_alarm", alarm, 16'h1059);
    SPDT_set = 1'b1;
    tick();
    check("spdt_reenter", {14'd0, edit_field}, 16'h0001);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    check("pre_reset_edit", edit_value, 16'h1000);

    // Asynchronous reset mid-EDIT_M, observed between clock edges.
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("arst_alarm", alarm, 16'h0700);
    check("arst_edit", edit_value, 16'h0700);
    check("arst_valid", {15'd0, alarm_valid}, 16'd0);
    check("arst_field", {14'd0, edit_field}, 16'd0);
    SPDT_set = 1'b0;
    #1 resetn = 1'b1;
    tick();
    check("post_arst_field", {14'd0, edit_field}, 16'd0);
    check("post_arst_alarm", alarm, 16'h0700);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
